// File: rtl/filter_peak_meter_if.sv
// Purpose : bundles the sample stream, start command and result handshake of
//           filter_peak_meter into one bus.
// Signals : sample_en/in   - sample strobe and signed WIDTH-bit sample
//           start          - begin a measurement
//           busy           - measurement in progress (SETTLE or ACCUM)
//           result_valid/result_ready - result handshake
//           peak/mean      - unsigned WIDTH-bit results
// Modports: master = sample source / result consumer, slave = meter.
interface filter_peak_meter_if #(
    parameter int unsigned WIDTH = 11
);
    logic             sample_en;
    logic [WIDTH-1:0] in;
    logic             start;
    logic             busy;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] peak;
    logic [WIDTH-1:0] mean;

    modport master (
        output sample_en, in, start, result_ready,
        input  busy, result_valid, peak, mean
    );

    modport slave (
        input  sample_en, in, start, result_ready,
        output busy, result_valid, peak, mean
    );
endinterface

// File: rtl/filter_peak_meter.sv
// Purpose : measures the amplitude of the IIR filter output stream. After a
//           start command it discards SKIP settling samples, then accumulates
//           2^LOG2_WIN samples and reports peak |x| and floor(mean |x|)
//           through a valid/ready handshake.
// Ports   : clk   - system clock
//           reset - synchronous active-low reset
//           bus   - filter_peak_meter_if slave (stream, start, results)
module filter_peak_meter #(
    parameter int unsigned WIDTH    = 11,
    parameter int unsigned LOG2_WIN = 7,
    parameter int unsigned SKIP     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    filter_peak_meter_if.slave   bus
);

    localparam int unsigned ACC_W     = WIDTH + LOG2_WIN;
    localparam int unsigned SKIP_W    = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam int unsigned SKIP_LAST = (SKIP == 0) ? 0 : SKIP - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACCUM  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [LOG2_WIN-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    pk_q, pk_d;
    logic [WIDTH-1:0]    peak_q, peak_d;
    logic [WIDTH-1:0]    mean_q, mean_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;

    logic [WIDTH-1:0]    abs_c;
    logic [ACC_W-1:0]    acc_sum_c;
    logic [WIDTH-1:0]    pk_max_c;
    state_e              entry_c;

    // |in| modulo 2^WIDTH: the most negative input maps to 2^(WIDTH-1),
    // which is still representable as an unsigned WIDTH-bit value.
    always_comb begin
        abs_c     = bus.in[WIDTH-1] ? (WIDTH'(0) - bus.in) : bus.in;
        acc_sum_c = acc_q + ACC_W'(abs_c);
        pk_max_c  = (abs_c > pk_q) ? abs_c : pk_q;
        entry_c   = (SKIP == 0) ? S_ACCUM : S_SETTLE;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        pk_d    = pk_q;
        peak_d  = peak_q;
        mean_d  = mean_q;

        case (state_q)
            S_IDLE: begin
                // A strobe coincident with start is deliberately not counted.
                if (bus.start) begin
                    skip_d  = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    pk_d    = '0;
                    state_d = entry_c;
                end
            end
            S_SETTLE: begin
                if (bus.sample_en) begin
                    if (skip_q == SKIP_W'(SKIP_LAST)) begin
                        state_d = S_ACCUM;
                    end else begin
                        skip_d = skip_q + SKIP_W'(1);
                    end
                end
            end
            S_ACCUM: begin
                if (bus.sample_en) begin
                    acc_d = acc_sum_c;
                    pk_d  = pk_max_c;
                    cnt_d = cnt_q + LOG2_WIN'(1);
                    if (cnt_q == '1) begin
                        peak_d  = pk_max_c;
                        mean_d  = acc_sum_c[ACC_W-1:LOG2_WIN];
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Strobes here are dropped; start only counts with the accept.
                if (valid_q && bus.result_ready) begin
                    if (bus.start) begin
                        skip_d  = '0;
                        cnt_d   = '0;
                        acc_d   = '0;
                        pk_d    = '0;
                        state_d = entry_c;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d == S_SETTLE) || (state_d == S_ACCUM);
        valid_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            skip_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            pk_q    <= '0;
            peak_q  <= '0;
            mean_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            pk_q    <= pk_d;
            peak_q  <= peak_d;
            mean_q  <= mean_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.peak         = peak_q;
    assign bus.mean         = mean_q;

endmodule

// File: tb/tb_filter_peak_meter.sv
// Directed bench for filter_peak_meter: a table of measurement scenarios
// with hand-computed peak/mean, plus sequences for result hold/back-to-back
// start and mid-measurement reset.
module tb_filter_peak_meter;

    localparam int unsigned W    = 11;
    localparam int          SKIP = 16;
    localparam int          WIN  = 128;

    typedef struct {
        int v0, v1, v2, v3;   // window samples repeat with period 4
        int settle;           // value fed during the settling interval
        int period;           // one strobe every 'period' clocks
        int exp_peak;
        int exp_mean;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    vec_t tbl [6];

    filter_peak_meter_if #(.WIDTH(W)) bus ();

    filter_peak_meter #(.WIDTH(W), .LOG2_WIN(7), .SKIP(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick(input vec_t t, input int i);
        case (i % 4)
            0:       return t.v0;
            1:       return t.v1;
            2:       return t.v2;
            default: return t.v3;
        endcase
    endfunction

    // Start from IDLE with a coincident (uncounted) strobe; returns busy seen.
    task automatic issue_start(input int settle, input string tag, output int busy_seen);
        bus.start     = 1'b1;
        bus.sample_en = 1'b1;
        bus.in        = W'(settle);
        tick;
        bus.start     = 1'b0;
        bus.sample_en = 1'b0;
        busy_seen     = int'(bus.busy);
        check({tag, " busy after start"}, int'(bus.busy), 1);
    endtask

    // Feed settle + window strobes and check timing and results.
    task automatic feed(input vec_t t, input string tag, input int busy_init);
        int busy_cnt;
        int early;
        busy_cnt = busy_init;
        early    = 0;
        for (int s = 0; s < SKIP + WIN; s++) begin
            for (int p = 0; p < t.period; p++) begin
                bus.sample_en = (p == t.period - 1);
                bus.in        = (s < SKIP) ? W'(t.settle) : W'(pick(t, s - SKIP));
                tick;
                if (bus.busy) busy_cnt++;
                if (bus.result_valid && !(s == SKIP + WIN - 1 && p == t.period - 1)) early++;
            end
        end
        bus.sample_en = 1'b0;
        check({tag, " early valid"}, early, 0);
        check({tag, " busy cycles"}, busy_cnt, t.period * (SKIP + WIN));
        check({tag, " valid"}, int'(bus.result_valid), 1);
        check({tag, " busy end"}, int'(bus.busy), 0);
        check({tag, " peak"}, int'(bus.peak), t.exp_peak);
        check({tag, " mean"}, int'(bus.mean), t.exp_mean);
    endtask

    task automatic accept(input vec_t t, input string tag);
        bus.result_ready = 1'b1;
        tick;
        bus.result_ready = 1'b0;
        check({tag, " valid after accept"}, int'(bus.result_valid), 0);
        check({tag, " busy after accept"}, int'(bus.busy), 0);
        tick;
        check({tag, " peak retained"}, int'(bus.peak), t.exp_peak);
        check({tag, " mean retained"}, int'(bus.mean), t.exp_mean);
    endtask

    initial begin
        int b;
        n_cmp = 0;
        n_bad = 0;

        //            v0     v1     v2     v3   settle  per  peak  mean
        tbl[0] = '{  100,   100,   100,   100,      0,   1,  100,  100};
        tbl[1] = '{-1024, -1024, -1024, -1024,  -1024,   1, 1024, 1024};
        tbl[2] = '{  300,  -500,   300,  -500,  -1000,   1,  500,  400};
        tbl[3] = '{    0,  1023,     0, -1023,      0,   3, 1023,  511};
        tbl[4] = '{    5,    -6,     7,    -8,   1023,   2,    8,    6};
        tbl[5] = '{   -1,     0,     0,     0,   -700,   1,    1,    0};

        bus.sample_en    = 1'b0;
        bus.in           = '0;
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
        reset            = 1'b0;
        tick;
        tick;
        check("reset busy",  int'(bus.busy), 0);
        check("reset valid", int'(bus.result_valid), 0);
        check("reset peak",  int'(bus.peak), 0);
        check("reset mean",  int'(bus.mean), 0);
        reset = 1'b1;
        tick;

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            issue_start(tbl[i].settle, tag, b);
            feed(tbl[i], tag, b);
            accept(tbl[i], tag);
        end

        // Result held in DONE while start/strobes toggle without ready.
        issue_start(0, "hold", b);
        feed(tbl[0], "hold", b);
        for (int i = 0; i < 20; i++) begin
            bus.start     = i[0];
            bus.sample_en = i[1];
            bus.in        = W'($urandom_range(0, 2047));
            tick;
            check($sformatf("hold%0d valid", i), int'(bus.result_valid), 1);
            check($sformatf("hold%0d busy", i),  int'(bus.busy), 0);
            check($sformatf("hold%0d peak", i),  int'(bus.peak), 100);
            check($sformatf("hold%0d mean", i),  int'(bus.mean), 100);
        end
        // Accept with start: back-to-back measurement.
        bus.sample_en    = 1'b0;
        bus.start        = 1'b1;
        bus.result_ready = 1'b1;
        tick;
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
        check("b2b busy", int'(bus.busy), 1);
        check("b2b valid", int'(bus.result_valid), 0);
        feed(tbl[2], "b2b", int'(bus.busy));
        accept(tbl[2], "b2b");

        // Reset for one cycle at window sample 60.
        issue_start(-1000, "rst", b);
        for (int s = 0; s < SKIP + 60; s++) begin
            bus.sample_en = 1'b1;
            bus.in        = W'(1000);
            tick;
        end
        reset         = 1'b0;
        bus.sample_en = 1'b1;
        tick;
        reset         = 1'b1;
        bus.sample_en = 1'b0;
        check("rst busy",  int'(bus.busy), 0);
        check("rst valid", int'(bus.result_valid), 0);
        check("rst peak",  int'(bus.peak), 0);
        check("rst mean",  int'(bus.mean), 0);
        bus.sample_en = 1'b1;
        tick;
        tick;
        bus.sample_en = 1'b0;
        check("rst stays idle", int'(bus.busy), 0);
        issue_start(0, "post_rst", b);
        feed(tbl[4], "post_rst", b);
        accept(tbl[4], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
